// File: rtl/fpga_io_pkg.sv
// Shared types and default timing constants for the board I/O blocks (buttons, LED blinkers).
package fpga_io_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int unsigned CLK_HZ        = 50_000_000;
  localparam int unsigned DEBOUNCE_20MS = CLK_HZ / 50;
  localparam int unsigned LONG_1S       = CLK_HZ;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser for asynchronous inputs; reset value is a parameter.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fpga_button_in.sv
// Push-button front end: synchronise, debounce, and emit press/release/long-press strobes,
// a stable level and a wrapping press counter.
module fpga_button_in
  import fpga_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_20MS,
  parameter int unsigned LONG_PRESS_CYCLES = LONG_1S,
  parameter bit          ACTIVE_LOW        = 1'b1,
  parameter int unsigned CNT_W             = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_raw,
  output logic             btn_level,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             long_pulse,
  output logic [CNT_W-1:0] press_count
);

  localparam int unsigned DCNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HCNT_W = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HCNT_W-1:0] HCNT_LONG = HCNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HCNT_W-1:0] HCNT_SAT  = HCNT_W'(LONG_PRESS_CYCLES);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("fpga_button_in: DEBOUNCE_CYCLES must be >= 2");
  end
  if (LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
    $error("fpga_button_in: LONG_PRESS_CYCLES must exceed DEBOUNCE_CYCLES");
  end

  btn_state_t        state;
  logic [DCNT_W-1:0] dcnt;
  logic [HCNT_W-1:0] hcnt;
  logic              long_done;
  logic              p;
  logic              s;

  // Normalise so that 1 always means pressed, then synchronise.
  assign p = ACTIVE_LOW ? ~btn_raw : btn_raw;

  sync_2ff #(
    .RESET_VAL (1'b0)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (p),
    .q     (s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      dcnt          <= '0;
      hcnt          <= '0;
      long_done     <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      press_count   <= '0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;

      case (state)
        IDLE: begin
          if (s) begin
            state <= PRESS_WAIT;
            dcnt  <= '0;
          end
        end

        PRESS_WAIT: begin
          if (!s) begin
            state <= IDLE;
          end else if (dcnt == DCNT_LAST) begin
            state       <= HELD;
            press_pulse <= 1'b1;
            btn_level   <= 1'b1;
            press_count <= press_count + CNT_W'(1);
            hcnt        <= '0;
            long_done   <= 1'b0;
          end else begin
            dcnt <= dcnt + DCNT_W'(1);
          end
        end

        HELD: begin
          if (!s) begin
            state <= RELEASE_WAIT;
            dcnt  <= '0;
          end else begin
            if (hcnt != HCNT_SAT) begin
              hcnt <= hcnt + HCNT_W'(1);
            end
            // Fires once per press; long_done survives release bounces.
            if (hcnt == HCNT_LONG && !long_done) begin
              long_pulse <= 1'b1;
              long_done  <= 1'b1;
            end
          end
        end

        RELEASE_WAIT: begin
          if (s) begin
            state <= HELD;
          end else if (dcnt == DCNT_LAST) begin
            state         <= IDLE;
            release_pulse <= 1'b1;
            btn_level     <= 1'b0;
          end else begin
            dcnt <= dcnt + DCNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_button_in.sv
// Directed bench for fpga_button_in with short debounce/long-press timing.
module tb_fpga_button_in;

  localparam int unsigned DEB  = 4;
  localparam int unsigned LONG = 10;
  localparam int unsigned CW   = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          btn_raw = 1'b1;
  logic          btn_level;
  logic          press_pulse;
  logic          release_pulse;
  logic          long_pulse;
  logic [CW-1:0] press_count;

  int n_cmp = 0;
  int n_bad = 0;

  fpga_button_in #(
    .DEBOUNCE_CYCLES   (DEB),
    .LONG_PRESS_CYCLES (LONG),
    .ACTIVE_LOW        (1'b1),
    .CNT_W             (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_raw       (btn_raw),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .press_count   (press_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Level/pulses/count packed as {level, press, release, long, count}.
  task automatic chk_quiet(input string tag, input logic lvl, input logic [CW-1:0] cnt);
    chk(tag, 8'({btn_level, press_pulse, release_pulse, long_pulse, press_count}),
        8'({lvl, 3'b000, cnt}));
  endtask

  // Pin goes to pressed; press_pulse must appear right after the 7th edge, for one cycle.
  task automatic do_press(input logic [CW-1:0] exp_cnt);
    btn_raw = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("press_wait", 8'({press_pulse, btn_level}), 8'd0);
    end
    tick();
    chk("press_pulse", 8'(press_pulse), 8'd1);
    chk("press_level", 8'(btn_level), 8'd1);
    chk("press_count", 8'(press_count), 8'(exp_cnt));
    tick();
    chk("press_single", 8'({press_pulse, long_pulse}), 8'd0);
  endtask

  task automatic do_release();
    btn_raw = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("release_wait", 8'({release_pulse, btn_level}), 8'd1);
    end
    tick();
    chk("release_pulse", 8'(release_pulse), 8'd1);
    chk("release_level", 8'(btn_level), 8'd0);
    tick();
    chk("release_single", 8'(release_pulse), 8'd0);
  endtask

  initial begin
    // 1: reset with the pin idle
    reset   = 1'b1;
    btn_raw = 1'b1;
    repeat (3) tick();
    chk_quiet("reset_state", 1'b0, 2'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_quiet("idle_quiet", 1'b0, 2'd0);
    end

    // 2 + 4: clean press held ~30 cycles, long pulse 10 cycles after press pulse
    do_press(2'd1);
    for (int i = 2; i <= 22; i++) begin
      tick();
      chk("long_timing", 8'({long_pulse, press_pulse}), (i == 10) ? 8'h02 : 8'h00);
    end
    do_release();

    // 3: bounce shorter than the debounce window
    btn_raw = 1'b0;
    repeat (3) begin tick(); chk_quiet("bounce", 1'b0, 2'd1); end
    btn_raw = 1'b1;
    tick(); chk_quiet("bounce", 1'b0, 2'd1);
    btn_raw = 1'b0;
    repeat (3) begin tick(); chk_quiet("bounce", 1'b0, 2'd1); end
    btn_raw = 1'b1;
    repeat (8) begin tick(); chk_quiet("bounce", 1'b0, 2'd1); end

    // 6: reset while in PRESS_WAIT, button kept down
    btn_raw = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    repeat (3) begin tick(); chk_quiet("mid_reset", 1'b0, 2'd0); end
    reset = 1'b0;
    do_press(2'd1);
    do_release();

    // 5: counter wrap, with a one-cycle release bounce during the second hold
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    do_press(2'd1);
    do_release();
    do_press(2'd2);
    btn_raw = 1'b1;
    tick();
    btn_raw = 1'b0;
    repeat (10) begin
      tick();
      chk("held_bounce", 8'({release_pulse, btn_level}), 8'd1);
    end
    do_release();
    do_press(2'd3);
    do_release();
    do_press(2'd0);
    do_release();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
